// File: rtl/ecc_scrub_store_pkg.sv
// Shared SECDED(13,8) constants, decode status and scrub FSM states.
// Provides secded_syndrome() for the storage stage decoder.
package ecc_pkg;

  localparam int N       = 13;
  localparam int K       = 8;
  localparam int EXT_POS = 12;

  localparam int DATA_POS [K] = '{2, 4, 5, 6, 8, 9, 10, 11};
  localparam int PAR_POS  [4] = '{0, 1, 3, 7};

  typedef enum logic [1:0] {
    CLEAN,
    CORRECTED,
    UNCORRECTABLE
  } dec_stat_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WB,
    S_NEXT
  } scrub_st_e;

  // Syndrome is the 1-based position of a single flipped bit in [11:0].
  function automatic logic [3:0] secded_syndrome(
    input logic [N-1:0] cw
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < EXT_POS; i++) begin
      for (int j = 0; j < 4; j++) begin
        if ((((i + 1) >> j) % 2) == 1) begin
          s[j] = s[j] ^ cw[i];
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ecc_scrub_store_if.sv
// Host-side bus of the codeword store: write, read, scrub control, stats.
// master = host/bench side, slave = ecc_scrub_store.
interface ecc_scrub_store_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [39:0]       wr_codeword;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_error_corrected;
  logic              rd_error_detected;
  logic              scrub_en;
  logic [15:0]       scrub_interval;
  logic              scrub_busy;
  logic              clr_counts;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;
  logic              uncorr_flag;
  logic [ADDR_W-1:0] uncorr_addr;

  modport master (
    output wr_en, wr_addr, wr_codeword,
    output rd_en, rd_addr,
    output scrub_en, scrub_interval, clr_counts,
    input  rd_valid, rd_data,
    input  rd_error_corrected, rd_error_detected,
    input  scrub_busy, corr_count, uncorr_count,
    input  uncorr_flag, uncorr_addr
  );

  modport slave (
    input  wr_en, wr_addr, wr_codeword,
    input  rd_en, rd_addr,
    input  scrub_en, scrub_interval, clr_counts,
    output rd_valid, rd_data,
    output rd_error_corrected, rd_error_detected,
    output scrub_busy, corr_count, uncorr_count,
    output uncorr_flag, uncorr_addr
  );

endinterface

// File: rtl/ecc_scrub_store_decode.sv
// Combinational SECDED(13,8) decoder: cw -> data, corrected cw, status.
// Ports: cw in, data/cw_fix/stat out.
module secded13_decode
  import ecc_pkg::*;
(
  input  logic [N-1:0] cw,
  output logic [K-1:0] data,
  output logic [N-1:0] cw_fix,
  output dec_stat_e    stat
);

  logic [3:0]   syn;
  logic         pe;
  logic [N-1:0] flip;

  always_comb begin
    syn  = secded_syndrome(cw);
    pe   = cw[EXT_POS] ^ (^cw[EXT_POS-1:0]);
    flip = '0;
    stat = CLEAN;
    unique case (1'b1)
      (syn == 4'd0) && !pe: stat = CLEAN;
      (syn == 4'd0) && pe: begin
        flip[EXT_POS] = 1'b1;
        stat          = CORRECTED;
      end
      (syn != 4'd0) && pe && (syn <= 4'd12): begin
        flip[syn - 4'd1] = 1'b1;
        stat             = CORRECTED;
      end
      default: stat = UNCORRECTABLE;
    endcase
    // flip stays zero when uncorrectable: data goes out raw
    cw_fix = cw ^ flip;
    for (int i = 0; i < K; i++) begin
      data[i] = cw_fix[DATA_POS[i]];
    end
  end

endmodule

// File: rtl/ecc_scrub_store.sv
// SECDED codeword store with corrected host reads and background scrub.
// Ports: clk, rst (sync, active high), bus (ecc_scrub_store_if.slave).
module ecc_scrub_store
  import ecc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  ecc_scrub_store_if.slave bus
);

  logic [N-1:0]      mem [DEPTH];
  logic [N-1:0]      mem_q;
  logic              rd_go, wr_go;
  logic [ADDR_W-1:0] rd_a, wr_a;
  logic [N-1:0]      wr_d;

  scrub_st_e         state_q, state_d;
  logic [15:0]       wait_q, wait_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              chk_ph_q, abort_q;
  logic              scrub_rd, scrub_wr, hit;
  dec_stat_e         sc_stat;
  logic [N-1:0]      sc_cw;

  logic              h1;
  logic [ADDR_W-1:0] h1_addr;
  logic [K-1:0]      dec_data;
  logic [N-1:0]      dec_cw;
  dec_stat_e         dec_stat;
  logic              h_corr, h_unc, s_corr, s_unc;
  logic              unused_cw_hi;

  assign unused_cw_hi = ^bus.wr_codeword[39:N];

  // Host owns both ports whenever it asks; scrub uses leftovers.
  assign rd_go = bus.rd_en | scrub_rd;
  assign rd_a  = bus.rd_en ? bus.rd_addr : ptr_q;
  assign wr_go = bus.wr_en | scrub_wr;
  assign wr_a  = bus.wr_en ? bus.wr_addr : ptr_q;
  assign wr_d  = bus.wr_en ? bus.wr_codeword[N-1:0] : sc_cw;

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_a] <= wr_d;
    if (rd_go) mem_q <= mem[rd_a];
  end

  secded13_decode u_dec (
    .cw     (mem_q),
    .data   (dec_data),
    .cw_fix (dec_cw),
    .stat   (dec_stat)
  );

  assign h_corr = h1 && (dec_stat == CORRECTED);
  assign h_unc  = h1 && (dec_stat == UNCORRECTABLE);
  assign s_corr = (state_q == S_CHECK) && chk_ph_q
                  && (sc_stat == CORRECTED);
  assign s_unc  = (state_q == S_CHECK) && chk_ph_q
                  && (sc_stat == UNCORRECTABLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      h1                     <= 1'b0;
      h1_addr                <= '0;
      bus.rd_valid           <= 1'b0;
      bus.rd_data            <= '0;
      bus.rd_error_corrected <= 1'b0;
      bus.rd_error_detected  <= 1'b0;
    end else begin
      h1                     <= bus.rd_en;
      h1_addr                <= bus.rd_addr;
      bus.rd_valid           <= h1;
      bus.rd_error_corrected <= h_corr;
      bus.rd_error_detected  <= h_unc;
      if (h1) bus.rd_data <= dec_data;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       inc
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Clear is applied before same-cycle events are added.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.corr_count   <= '0;
      bus.uncorr_count <= '0;
      bus.uncorr_flag  <= 1'b0;
      bus.uncorr_addr  <= '0;
    end else begin
      bus.corr_count <= sat_add(
        bus.clr_counts ? '0 : bus.corr_count,
        {1'b0, h_corr} + {1'b0, s_corr});
      bus.uncorr_count <= sat_add(
        bus.clr_counts ? '0 : bus.uncorr_count,
        {1'b0, h_unc} + {1'b0, s_unc});
      bus.uncorr_flag <= (bus.uncorr_flag & ~bus.clr_counts)
                         | h_unc | s_unc;
      if (s_unc)      bus.uncorr_addr <= ptr_q;
      else if (h_unc) bus.uncorr_addr <= h1_addr;
    end
  end

  assign bus.scrub_busy = (state_q != S_IDLE) && (state_q != S_WAIT);

  // A host write to the scrubbed word after its read makes sc_cw stale.
  assign hit = bus.wr_en && (bus.wr_addr == ptr_q)
               && (scrub_rd || state_q == S_CHECK || state_q == S_WB);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    scrub_rd = 1'b0;
    scrub_wr = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.scrub_en) begin
        state_d = S_WAIT;
        wait_d  = bus.scrub_interval;
      end
      S_WAIT: begin
        if (!bus.scrub_en)       state_d = S_IDLE;
        else if (wait_q == '0)   state_d = S_READ;
        else                     wait_d  = wait_q - 16'd1;
      end
      S_READ: if (!bus.rd_en) begin
        scrub_rd = 1'b1;
        state_d  = S_CHECK;
      end
      S_CHECK: if (chk_ph_q) begin
        state_d = (sc_stat == CORRECTED) ? S_WB : S_NEXT;
      end
      S_WB: begin
        if (abort_q) begin
          state_d = S_NEXT;
        end else if (!bus.wr_en) begin
          scrub_wr = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = bus.scrub_en ? S_WAIT : S_IDLE;
        wait_d  = bus.scrub_interval;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      ptr_q    <= '0;
      chk_ph_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      chk_ph_q <= (state_q == S_CHECK) && !chk_ph_q;
      if (state_q == S_NEXT) ptr_q <= ptr_q + 1'b1;
      if (state_q == S_NEXT) abort_q <= 1'b0;
      else if (hit)          abort_q <= 1'b1;
    end
  end

  // First CHECK cycle: mem_q holds the scrub word; latch its decode.
  always_ff @(posedge clk) begin
    if (state_q == S_CHECK && !chk_ph_q) begin
      sc_stat <= dec_stat;
      sc_cw   <= dec_cw;
    end
  end

endmodule
